// File: rtl/key_pulse_gen.sv
// Push-button conditioner: synchronizer, debounce filter and press/auto-repeat FSM
// producing one-cycle strobes suitable for a counter enable.
module key_pulse_gen #(
    parameter int SYNC_STAGES   = 2,
    parameter int DB_CYCLES     = 16,
    parameter int HOLD_CYCLES   = 64,
    parameter int REPEAT_CYCLES = 16
) (
    input  logic Clk,
    input  logic resetn,
    input  logic key,
    input  logic rep_en,
    output logic pulse,
    output logic pressed,
    output logic rep_active
);

    localparam int DB_W   = $clog2(DB_CYCLES + 1);
    localparam int TMAX   = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int TMR_W  = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] REP_LAST  = TMR_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_REPEAT
    } state_t;

    // ------------------------------------------------------------------
    // Synchronizer chain; stage 0 captures the asynchronous pin.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   key_s;

    always_ff @(posedge Clk or negedge resetn) begin
        if (!resetn) begin
            sync_q[0] <= 1'b0;
        end else begin
            sync_q[0] <= key;
        end
    end

    generate
        for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge Clk or negedge resetn) begin
                if (!resetn) begin
                    sync_q[gi] <= 1'b0;
                end else begin
                    sync_q[gi] <= sync_q[gi-1];
                end
            end
        end
    endgenerate

    assign key_s = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Debounce: a new level must persist DB_CYCLES consecutive cycles.
    // ------------------------------------------------------------------
    logic [DB_W-1:0] db_cnt_q;
    logic [DB_W-1:0] db_cnt_d;
    logic            pressed_q;
    logic            pressed_d;

    always_comb begin
        db_cnt_d  = db_cnt_q;
        pressed_d = pressed_q;
        if (key_s == pressed_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            pressed_d = key_s;
            db_cnt_d  = '0;
        end else begin
            db_cnt_d = db_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge resetn) begin
        if (!resetn) begin
            db_cnt_q  <= '0;
            pressed_q <= 1'b0;
        end else begin
            db_cnt_q  <= db_cnt_d;
            pressed_q <= pressed_d;
        end
    end

    // ------------------------------------------------------------------
    // Press / auto-repeat FSM with registered strobe and repeat flag.
    // ------------------------------------------------------------------
    state_t           state_q;
    logic [TMR_W-1:0] timer_q;
    logic             pulse_q;
    logic             rep_active_q;
    logic             timer_max;

    // One shared terminal-count compare, selected by the phase being timed.
    assign timer_max = (state_q == S_REPEAT) ? (timer_q == REP_LAST)
                                             : (timer_q == HOLD_LAST);

    always_ff @(posedge Clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            pulse_q      <= 1'b0;
            rep_active_q <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    rep_active_q <= 1'b0;
                    if (pressed_q) begin
                        pulse_q <= 1'b1;
                        timer_q <= '0;
                        state_q <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (!pressed_q) begin
                        state_q <= S_IDLE;
                    end else if (rep_en && timer_max) begin
                        pulse_q      <= 1'b1;
                        timer_q      <= '0;
                        state_q      <= S_REPEAT;
                        rep_active_q <= 1'b1;
                    end else if (!timer_max) begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                S_REPEAT: begin
                    // Release takes priority over a coinciding timer expiry.
                    if (!pressed_q) begin
                        state_q      <= S_IDLE;
                        rep_active_q <= 1'b0;
                    end else if (!rep_en) begin
                        state_q      <= S_HOLD;
                        timer_q      <= '0;
                        rep_active_q <= 1'b0;
                    end else if (timer_max) begin
                        pulse_q <= 1'b1;
                        timer_q <= '0;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    timer_q      <= '0;
                    rep_active_q <= 1'b0;
                end
            endcase
        end
    end

    assign pulse      = pulse_q;
    assign pressed    = pressed_q;
    assign rep_active = rep_active_q;

endmodule
